// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: Mode encodings and
// the helper that sizes the shift counter.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHR   = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_LOAD  = 3'b011;
    localparam logic [2:0] MODE_ROR   = 3'b100;
    localparam logic [2:0] MODE_ROL   = 3'b101;
    localparam logic [2:0] MODE_CLEAR = 3'b110;

    // Counter must be able to hold the value WIDTH itself (saturation point).
    function automatic int usr_count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/usr_shift_counter.sv
// Saturating count of shifts since the last load/clear, with a one-cycle
// Done pulse on the edge where the count reaches WIDTH.
module usr_shift_counter
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clear,
    input  logic shift,
    output logic done
);

    localparam int CW = usr_count_width(WIDTH);
    localparam logic [CW-1:0] COUNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] COUNT_LAST = CW'(WIDTH - 1);

    logic [CW-1:0] count_reg;
    logic          done_reg;

    // Clear wins over shift; once saturated further shifts neither count nor re-fire Done.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (clear) begin
                count_reg <= '0;
            end else if (shift && (count_reg != COUNT_FULL)) begin
                count_reg <= count_reg + 1'b1;
                done_reg  <= (count_reg == COUNT_LAST);
            end
        end
    end

    assign done = done_reg;

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: hold, serial shift both ways, parallel load,
// clear and (when the USR_ROTATE_EN macro is defined) rotate both ways.
// Without USR_ROTATE_EN the rotate encodings behave as HOLD.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic [2:0]       Mode,
    input  logic             SerIn,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             SoutR,
    output logic             SoutL,
    output logic             Done
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] shr_val;
    logic [WIDTH-1:0] shl_val;
    logic             shift_strobe;
    logic             clear_strobe;

    // Per-bit neighbour selection for the two serial shift directions.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift_bits
            if (gi == WIDTH - 1) begin : g_top
                assign shr_val[gi] = SerIn;
            end else begin : g_not_top
                assign shr_val[gi] = q_reg[gi+1];
            end
            if (gi == 0) begin : g_bottom
                assign shl_val[gi] = SerIn;
            end else begin : g_not_bottom
                assign shl_val[gi] = q_reg[gi-1];
            end
        end
    endgenerate

    // Mode multiplexer: next register value plus the counter strobes.
    always_comb begin
        q_next       = q_reg;
        shift_strobe = 1'b0;
        clear_strobe = 1'b0;
        if (En) begin
            case (Mode)
                MODE_SHR: begin
                    q_next       = shr_val;
                    shift_strobe = 1'b1;
                end
                MODE_SHL: begin
                    q_next       = shl_val;
                    shift_strobe = 1'b1;
                end
                MODE_LOAD: begin
                    q_next       = D;
                    clear_strobe = 1'b1;
                end
`ifdef USR_ROTATE_EN
                MODE_ROR: begin
                    q_next       = {q_reg[0], q_reg[WIDTH-1:1]};
                    shift_strobe = 1'b1;
                end
                MODE_ROL: begin
                    q_next       = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
                    shift_strobe = 1'b1;
                end
`endif
                MODE_CLEAR: begin
                    q_next       = '0;
                    clear_strobe = 1'b1;
                end
                default: begin
                    q_next = q_reg;
                end
            endcase
        end
    end

    // Data register; reset overrides enable and mode.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            q_reg <= RESET_VALUE;
        end else begin
            q_reg <= q_next;
        end
    end

    usr_shift_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .Clk  (Clk),
        .Reset(Reset),
        .clear(clear_strobe),
        .shift(shift_strobe),
        .done (Done)
    );

    assign Q     = q_reg;
    assign SoutR = q_reg[0];
    assign SoutL = q_reg[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register (WIDTH=8, RESET_VALUE=8'hA5).
// The reference model follows USR_ROTATE_EN the same way the design does.
module tb_universal_shift_register;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       En = 1'b0;
    logic [2:0] Mode = 3'd0;
    logic       SerIn = 1'b0;
    logic [7:0] D = 8'h00;
    logic [7:0] Q;
    logic       SoutR;
    logic       SoutL;
    logic       Done;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: value, shifts since last load/clear, expected Done.
    logic [7:0] exp_q = 8'hA5;
    int         exp_cnt = 0;
    logic       exp_done = 1'b0;

    always #5 Clk = ~Clk;

    universal_shift_register #(
        .WIDTH(8),
        .RESET_VALUE(8'hA5)
    ) dut (
        .Clk(Clk), .Reset(Reset), .En(En), .Mode(Mode), .SerIn(SerIn),
        .D(D), .Q(Q), .SoutR(SoutR), .SoutL(SoutL), .Done(Done)
    );

    // Apply one cycle of stimulus, advance the model, sample 1 time unit after the edge.
    task automatic step(input logic rst, input logic en, input logic [2:0] mode,
                        input logic sin, input logic [7:0] d);
        logic shifted;
        int   v;
        Reset = rst; En = en; Mode = mode; SerIn = sin; D = d;
        shifted = 1'b0;
        v = int'(exp_q);
        exp_done = 1'b0;
        if (rst) begin
            exp_q = 8'hA5; exp_cnt = 0;
        end else if (en) begin
            case (mode)
                3'd1: begin v = v / 2 + (sin ? 128 : 0); shifted = 1'b1; end
                3'd2: begin v = (v * 2) % 256 + (sin ? 1 : 0); shifted = 1'b1; end
                3'd3: begin v = int'(d); exp_cnt = 0; end
`ifdef USR_ROTATE_EN
                3'd4: begin v = v / 2 + (v % 2) * 128; shifted = 1'b1; end
                3'd5: begin v = (v * 2) % 256 + v / 128; shifted = 1'b1; end
`endif
                3'd6: begin v = 0; exp_cnt = 0; end
                default: ;
            endcase
            exp_q = 8'(v);
            if (shifted && exp_cnt < 8) begin
                exp_cnt++;
                exp_done = (exp_cnt == 8);
            end
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'($urandom), 3'($urandom), 1'($urandom), 8'($urandom));
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 3'd0, 1'($urandom), 8'($urandom));
            vectors++;
            if (Q !== 8'hA5 || SoutR !== 1'b1 || SoutL !== 1'b1 || Done !== 1'b0) begin
                $display("FAIL reset_hold cycle %0d: Q=%h SoutR=%b SoutL=%b Done=%b, want Q=a5 SoutR=1 SoutL=1 Done=0",
                         i, Q, SoutR, SoutL, Done);
                miscompares++;
            end
        end
    endtask

    task automatic test_shr_serial();
        logic [7:0] pattern;
        pattern = 8'h96;
        step(1'b0, 1'b1, 3'd3, 1'b0, 8'h96);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (SoutR !== pattern[i]) begin
                $display("FAIL shr_soutr bit %0d: got %b want %b", i, SoutR, pattern[i]);
                miscompares++;
            end
            step(1'b0, 1'b1, 3'd1, 1'b0, 8'h00);
            vectors++;
            if (Done !== exp_done || Q !== exp_q) begin
                $display("FAIL shr_step %0d: Q=%h Done=%b want Q=%h Done=%b", i, Q, Done, exp_q, exp_done);
                miscompares++;
            end
        end
        vectors++;
        if (Q !== 8'h00 || Done !== 1'b1) begin
            $display("FAIL shr_final: Q=%h Done=%b want Q=00 Done=1", Q, Done);
            miscompares++;
        end
        step(1'b0, 1'b1, 3'd0, 1'b0, 8'h00);
        vectors++;
        if (Done !== 1'b0) begin
            $display("FAIL shr_done_width: Done=%b want 0", Done);
            miscompares++;
        end
    endtask

    task automatic test_rotate();
        int pulses;
        logic [7:0] want_q;
        pulses = 0;
        step(1'b0, 1'b1, 3'd3, 1'b0, 8'h01);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 3'd5, 1'($urandom), 8'($urandom));
            if (Done === 1'b1) pulses++;
            vectors++;
            if (Q !== exp_q || Done !== exp_done) begin
                $display("FAIL rol_step %0d: Q=%h Done=%b want Q=%h Done=%b", i, Q, Done, exp_q, exp_done);
                miscompares++;
            end
        end
        want_q = 8'h01;
        vectors++;
`ifdef USR_ROTATE_EN
        if (Q !== want_q || pulses != 1) begin
            $display("FAIL rol_final: Q=%h pulses=%0d want Q=01 pulses=1", Q, pulses);
            miscompares++;
        end
`else
        if (Q !== want_q || pulses != 0) begin
            $display("FAIL rol_disabled: Q=%h pulses=%0d want Q=01 pulses=0", Q, pulses);
            miscompares++;
        end
`endif
    endtask

    task automatic test_enable_gap();
        step(1'b0, 1'b1, 3'd3, 1'b0, 8'hFF);
        for (int i = 0; i < 13; i++) begin
            if (i >= 4 && i < 9)
                step(1'b0, 1'b0, 3'($urandom), 1'($urandom), 8'($urandom));
            else
                step(1'b0, 1'b1, 3'd2, 1'b0, 8'h00);
            vectors++;
            if (Q !== exp_q || Done !== (i == 12)) begin
                $display("FAIL enable_gap step %0d: Q=%h Done=%b want Q=%h Done=%b", i, Q, Done, exp_q, (i == 12));
                miscompares++;
            end
        end
        vectors++;
        if (Q !== 8'h00) begin
            $display("FAIL enable_gap_final: Q=%h want 00", Q);
            miscompares++;
        end
    endtask

    task automatic test_reset_midseq();
        step(1'b0, 1'b1, 3'd3, 1'b0, 8'h3C);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 3'd1, 1'($urandom), 8'h00);
        step(1'b1, 1'b1, 3'd1, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 3'd1, 1'($urandom), 8'h00);
            vectors++;
            if (Q !== exp_q || Done !== (i == 7)) begin
                $display("FAIL reset_midseq step %0d: Q=%h Done=%b want Q=%h Done=%b", i, Q, Done, exp_q, (i == 7));
                miscompares++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        step(1'b0, 1'b1, 3'd3, 1'b0, 8'($urandom));
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 3'd1, 1'($urandom), 8'h00);
            if (Done === 1'b1) pulses++;
            vectors++;
            if (Q !== exp_q || Done !== (i == 7)) begin
                $display("FAIL b2b step %0d: Q=%h Done=%b want Q=%h Done=%b", i, Q, Done, exp_q, (i == 7));
                miscompares++;
            end
        end
        vectors++;
        if (pulses != 1) begin
            $display("FAIL b2b_pulses: got %0d want 1", pulses);
            miscompares++;
        end
        step(1'b0, 1'b1, 3'd6, 1'b1, 8'hFF);
        vectors++;
        if (Q !== 8'h00 || Done !== 1'b0) begin
            $display("FAIL clear: Q=%h Done=%b want Q=00 Done=0", Q, Done);
            miscompares++;
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 3'd2, 1'($urandom), 8'h00);
            vectors++;
            if (Q !== exp_q || Done !== (i == 7)) begin
                $display("FAIL rearm step %0d: Q=%h Done=%b want Q=%h Done=%b", i, Q, Done, exp_q, (i == 7));
                miscompares++;
            end
        end
    endtask

    task automatic test_load_wins();
        step(1'b0, 1'b1, 3'd3, 1'b0, 8'h5A);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 3'd1, 1'b1, 8'h00);
        step(1'b0, 1'b1, 3'd3, 1'b0, 8'hC3);
        vectors++;
        if (Q !== 8'hC3 || Done !== 1'b0) begin
            $display("FAIL load_wins: Q=%h Done=%b want Q=c3 Done=0", Q, Done);
            miscompares++;
        end
    endtask

    task automatic test_random();
        logic [2:0] m;
        for (int i = 0; i < 400; i++) begin
            m = 3'($urandom);
            if ($urandom_range(0, 9) < 7) m = 3'($urandom_range(1, 2));
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) != 0), m, 1'($urandom), 8'($urandom));
            vectors++;
            if (Q !== exp_q || Done !== exp_done || SoutR !== exp_q[0] || SoutL !== exp_q[7]) begin
                $display("FAIL random %0d: Q=%h Done=%b SoutR=%b SoutL=%b want Q=%h Done=%b",
                         i, Q, Done, SoutR, SoutL, exp_q, exp_done);
                miscompares++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_shr_serial();
        test_rotate();
        test_enable_gap();
        test_reset_midseq();
        test_back_to_back();
        test_load_wins();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
